// File: rtl/s3g_rx.sv
// s3g_rx: receive-side S3G packet framer.
// Hunts for the 0xD5 start byte, captures length and payload (up to 16
// bytes), checks the CRC8 and presents a good payload on 16 parallel
// byte outputs with a one-cycle strobe. Bad or stalled packets are dropped
// and flagged with a one-cycle error strobe.
//
// Handshake: rx_valid is a one-cycle qualifier with no back-pressure; every
// byte with rx_valid=1 is consumed on that rising edge, and every effect
// (state change, strobe, output update) shows up in the following cycle.
module s3g_rx #(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 100000,
    parameter int CNT_W   = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       busy,
    output logic       packet_valid,
    output logic [7:0] payload_len,
    output logic [7:0] buf0,
    output logic [7:0] buf1,
    output logic [7:0] buf2,
    output logic [7:0] buf3,
    output logic [7:0] buf4,
    output logic [7:0] buf5,
    output logic [7:0] buf6,
    output logic [7:0] buf7,
    output logic [7:0] buf8,
    output logic [7:0] buf9,
    output logic [7:0] buf10,
    output logic [7:0] buf11,
    output logic [7:0] buf12,
    output logic [7:0] buf13,
    output logic [7:0] buf14,
    output logic [7:0] buf15,
    output logic       crc_err,
    output logic       len_err,
    output logic       timeout_err,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LEN  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_CRC  = 2'd3;

    // CRC8, polynomial x^8+x^2+x+1, MSB first, one byte per call.
    function automatic logic [7:0] crc8_d8(input logic [7:0] d, input logic [7:0] c);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
    endfunction

    logic [1:0]       r_state;
    logic [7:0]       r_rx_len;
    logic [4:0]       r_byte_cnt;
    logic [7:0]       r_crc;
    logic [CNT_W-1:0] r_to_cnt;
    logic [7:0]       r_shadow [16];
    logic [7:0]       r_buf    [16];
    logic [7:0]       r_payload_len;
    logic             r_packet_valid;
    logic             r_crc_err;
    logic             r_len_err;
    logic             r_timeout_err;

    logic [7:0]       w_crc_next;
    logic [4:0]       w_cnt_inc;
    logic             w_to_hit;
    logic             w_store;
    logic             w_good;

    assign w_crc_next = crc8_d8(rx_data, r_crc);
    assign w_cnt_inc  = r_byte_cnt + 5'd1;
    assign w_to_hit   = (r_to_cnt == CNT_W'(TIMEOUT - 1));
    assign w_store    = rx_valid && (r_state == S_DATA);
    assign w_good     = rx_valid && (r_state == S_CRC) && (rx_data == r_crc);

    // Framing FSM, CRC accumulation, inter-byte timeout and error strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_rx_len       <= '0;
            r_byte_cnt     <= '0;
            r_crc          <= '0;
            r_to_cnt       <= '0;
            r_packet_valid <= 1'b0;
            r_crc_err      <= 1'b0;
            r_len_err      <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_packet_valid <= 1'b0;
            r_crc_err      <= 1'b0;
            r_len_err      <= 1'b0;
            r_timeout_err  <= 1'b0;
            if (rx_valid) begin
                // A byte always beats the timeout, even on the limit cycle.
                r_to_cnt <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (rx_data == 8'hD5) begin
                            r_state    <= S_LEN;
                            r_crc      <= '0;
                            r_byte_cnt <= '0;
                        end
                    end
                    S_LEN: begin
                        r_rx_len <= rx_data;
                        if (rx_data > 8'(MAX_LEN)) begin
                            r_len_err <= 1'b1;
                            r_state   <= S_IDLE;
                        end else if (rx_data == 8'd0) begin
                            r_state <= S_CRC;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        // 0xD5 here is plain payload; no resynchronisation.
                        r_crc      <= w_crc_next;
                        r_byte_cnt <= w_cnt_inc;
                        if ({3'b000, w_cnt_inc} == r_rx_len) begin
                            r_state <= S_CRC;
                        end
                    end
                    default: begin
                        if (rx_data == r_crc) begin
                            r_packet_valid <= 1'b1;
                        end else begin
                            r_crc_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                endcase
            end else if (r_state != S_IDLE) begin
                if (w_to_hit) begin
                    r_timeout_err <= 1'b1;
                    r_state       <= S_IDLE;
                    r_to_cnt      <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // Shadow capture during payload; publish to the outputs only on a good CRC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_payload_len <= '0;
            for (int i = 0; i < 16; i++) begin
                r_shadow[i] <= '0;
                r_buf[i]    <= '0;
            end
        end else begin
            if (w_store) begin
                r_shadow[r_byte_cnt[3:0]] <= rx_data;
            end
            if (w_good) begin
                r_payload_len <= r_rx_len;
                // Shadow slots past the length may hold stale bytes; mask them.
                for (int i = 0; i < 16; i++) begin
                    r_buf[i] <= (8'(i) < r_rx_len) ? r_shadow[i] : 8'h00;
                end
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign dbg_state    = r_state;
    assign packet_valid = r_packet_valid;
    assign crc_err      = r_crc_err;
    assign len_err      = r_len_err;
    assign timeout_err  = r_timeout_err;
    assign payload_len  = r_payload_len;
    assign buf0         = r_buf[0];
    assign buf1         = r_buf[1];
    assign buf2         = r_buf[2];
    assign buf3         = r_buf[3];
    assign buf4         = r_buf[4];
    assign buf5         = r_buf[5];
    assign buf6         = r_buf[6];
    assign buf7         = r_buf[7];
    assign buf8         = r_buf[8];
    assign buf9         = r_buf[9];
    assign buf10        = r_buf[10];
    assign buf11        = r_buf[11];
    assign buf12        = r_buf[12];
    assign buf13        = r_buf[13];
    assign buf14        = r_buf[14];
    assign buf15        = r_buf[15];

endmodule

// File: tb/tb_s3g_rx.sv
// tb_s3g_rx: directed bench for the s3g_rx packet framer.
// Each event vector is {kind[1:0], payload_len[7:0], buf15..buf0[127:0]};
// kind 0 = good packet, 1 = crc_err, 2 = len_err, 3 = timeout_err.
module tb_s3g_rx;

    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       busy, packet_valid, crc_err, len_err, timeout_err;
    logic [7:0] payload_len;
    logic [7:0] buf0, buf1, buf2, buf3, buf4, buf5, buf6, buf7;
    logic [7:0] buf8, buf9, buf10, buf11, buf12, buf13, buf14, buf15;
    logic [1:0] dbg_state;

    s3g_rx #(.MAX_LEN(16), .TIMEOUT(TO), .CNT_W(17)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .packet_valid(packet_valid), .payload_len(payload_len),
        .buf0(buf0), .buf1(buf1), .buf2(buf2), .buf3(buf3),
        .buf4(buf4), .buf5(buf5), .buf6(buf6), .buf7(buf7),
        .buf8(buf8), .buf9(buf9), .buf10(buf10), .buf11(buf11),
        .buf12(buf12), .buf13(buf13), .buf14(buf14), .buf15(buf15),
        .crc_err(crc_err), .len_err(len_err), .timeout_err(timeout_err),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [137:0] exp_q[$];
    logic [7:0]   last_len  = 8'h00;
    logic [127:0] last_bufs = '0;
    logic [7:0]   pl [16];

    wire [127:0] obs_bufs = {buf15, buf14, buf13, buf12, buf11, buf10, buf9, buf8,
                             buf7, buf6, buf5, buf4, buf3, buf2, buf1, buf0};

    // Reference CRC8: bit-serial LFSR, poly 0x07, data MSB first.
    function automatic logic [7:0] crc_model(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [137:0] obs, input logic [137:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe pops one expected event and compares all outputs.
    always @(posedge clk) begin : monitor
        int           n_strobe;
        logic [1:0]   kind;
        logic [137:0] e;
        #1;
        if (rst && (packet_valid || crc_err || len_err || timeout_err)) begin
            n_strobe = int'(packet_valid) + int'(crc_err) + int'(len_err) + int'(timeout_err);
            check("single_strobe", 138'(n_strobe), 138'(1));
            kind = packet_valid ? 2'd0 : crc_err ? 2'd1 : len_err ? 2'd2 : 2'd3;
            n_checks++;
            assert (exp_q.size() != 0) begin
                n_pass++;
                e = exp_q.pop_front();
                check("event", {kind, payload_len, obs_bufs}, e);
            end else begin
                n_fail++;
                $error("FAIL unexpected_event observed=%h expected=none", {kind, payload_len, obs_bufs});
            end
        end
    end

    // Driver: one byte with rx_valid for a single edge, then gap idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Driver: whole framed packet; pushes the scoreboard expectation first.
    task automatic send_pkt(input logic [7:0] len, input logic [7:0] p [16],
                            input int gap, input bit corrupt);
        logic [7:0]   c;
        logic [127:0] bufs;
        c    = 8'h00;
        bufs = '0;
        if (len > 8'd16) begin
            exp_q.push_back({2'd2, last_len, last_bufs});
            send_byte(8'hD5, gap);
            send_byte(len, gap);
            return;
        end
        for (int i = 0; i < int'(len); i++) begin
            c = crc_model(c, p[i]);
            bufs[8*i +: 8] = p[i];
        end
        if (corrupt) begin
            exp_q.push_back({2'd1, last_len, last_bufs});
        end else begin
            last_len  = len;
            last_bufs = bufs;
            exp_q.push_back({2'd0, len, bufs});
        end
        send_byte(8'hD5, gap);
        send_byte(len, gap);
        for (int i = 0; i < int'(len); i++) send_byte(p[i], gap);
        send_byte(c ^ {7'd0, corrupt}, gap);
    endtask

    task automatic clear_pl();
        for (int i = 0; i < 16; i++) pl[i] = 8'h00;
    endtask

    // Watchdog
    initial begin
        #500000;
        $error("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // Directed sequence
    initial begin : stim
        int n;
        clear_pl();
        #2;
        check("reset_outputs",
              138'({busy, packet_valid, crc_err, len_err, timeout_err, dbg_state, payload_len, obs_bufs}),
              138'(0));
        #20;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Good packet with 3-cycle gaps
        pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
        send_pkt(8'd3, pl, 3, 1'b0);
        check("busy_after_good", 138'(busy), 138'(0));

        // Corrupt CRC: outputs hold previous packet
        send_pkt(8'd3, pl, 1, 1'b1);
        check("held_after_crc_err", {2'd0, payload_len, obs_bufs}, {2'd0, 8'd3, last_bufs});

        // Length too large
        send_pkt(8'h11, pl, 2, 1'b0);
        check("busy_after_len_err", 138'(busy), 138'(0));

        // Zero length
        clear_pl();
        send_pkt(8'd0, pl, 1, 1'b0);

        // Full 16-byte payload
        for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(0, 255));
        send_pkt(8'd16, pl, 1, 1'b0);
        check("buf15_max_len", 138'(buf15), 138'(pl[15]));

        // Garbage before frame
        send_byte(8'h00, 2);
        send_byte(8'hFF, 2);
        send_byte(8'h7E, 2);
        clear_pl();
        pl[0] = 8'hAA;
        send_pkt(8'd1, pl, 2, 1'b0);

        // 0xD5 inside payload
        pl[0] = 8'hD5; pl[1] = 8'h01;
        send_pkt(8'd2, pl, 1, 1'b0);

        // Timeout: exactly TO cycles after the last byte
        exp_q.push_back({2'd3, last_len, last_bufs});
        send_byte(8'hD5, 0);
        check("busy_in_packet", 138'(busy), 138'(1));
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        n = 0;
        while (!timeout_err && n < 4 * TO) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("timeout_latency", 138'(n), 138'(TO));
        @(posedge clk);
        #1;
        check("busy_after_timeout", 138'(busy), 138'(0));

        // Fresh packet after timeout, gaps one short of the limit
        pl[0] = 8'h5A; pl[1] = 8'hC3;
        send_pkt(8'd2, pl, TO - 1, 1'b0);
        send_pkt(8'd2, pl, 0, 1'b0);

        // Asynchronous reset mid-payload
        send_byte(8'hD5, 0);
        send_byte(8'h05, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        #3;
        rst = 1'b0;
        #1;
        check("async_reset_outputs", 138'({busy, dbg_state, payload_len, obs_bufs}), 138'(0));
        last_len  = 8'h00;
        last_bufs = '0;
        #17;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back good packets
        for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(0, 255));
        send_pkt(8'd4, pl, 0, 1'b0);
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_pkt(8'd3, pl, 0, 1'b0);

        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_drained", 138'(exp_q.size()), 138'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
